// File: rtl/wbc_btn_array_pkg.sv
// Shared types and helpers for the multi-channel button front end.
// Hold-FSM state encoding and counter width helper.
package wbc_btn_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_e;

  function automatic int cw(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/wbc_btn_chan.sv
// One button channel: synchroniser, debounce, press/release/click,
// long-press and auto-repeat, optional toggle output.
module wbc_btn_chan
  import wbc_btn_array_pkg::*;
#(
  parameter int DEBOUNCE   = 10,
  parameter int LONGKEY    = 1000,
  parameter int REPEAT     = 0,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit TOGGLE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_ms,
  input  logic but,
  output logic out,
  output logic press,
  output logic rel,
  output logic click,
  output logic long,
  output logic rpt
);

  localparam int DW = cw(DEBOUNCE);
  localparam int HW = cw(LONGKEY);
  localparam int RW = cw(REPEAT);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONGKEY - 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT - 1);

  logic pin;
  logic s1, s2, sp;
  logic acc, tog;
  logic [DW-1:0] db_cnt;
  logic commit, rise, fall;

  hold_e state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rep_cnt, rep_n;
  logic long_d, rpt_d;

  assign pin    = but ^ ACTIVE_LOW;
  assign commit = (s2 == sp) && (s2 != acc)
                  && ena_ms && (db_cnt == DMAX);
  assign rise   = commit & s2;
  assign fall   = commit & ~s2;
  assign out    = TOGGLE ? tog : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= pin;
      s2     <= pin;
      sp     <= pin;
      acc    <= pin;
      db_cnt <= '0;
      tog    <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      click  <= 1'b0;
      long   <= 1'b0;
      rpt    <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      sp <= s2;
      // An edge on s restarts the stability window even on a strobe.
      if (s2 != sp || s2 == acc) begin
        db_cnt <= '0;
      end else if (ena_ms) begin
        if (db_cnt == DMAX) begin
          acc    <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
      tog   <= tog ^ rise;
      press <= rise;
      rel   <= fall;
      click <= fall && (state != LONG);
      long  <= long_d;
      rpt   <= rpt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rep_cnt  <= rep_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rep_n   = rep_cnt;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    if (fall) begin
      state_n = IDLE;
      hold_n  = '0;
      rep_n   = '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (rise) begin
            state_n = HELD;
            hold_n  = '0;
            rep_n   = '0;
          end
        end
        (state == HELD): begin
          if (ena_ms) begin
            if (hold_cnt == HMAX) begin
              state_n = LONG;
              long_d  = 1'b1;
              rep_n   = '0;
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
        end
        (state == LONG): begin
          if (REPEAT != 0 && ena_ms) begin
            if (rep_cnt == RMAX) begin
              rpt_d = 1'b1;
              rep_n = '0;
            end else begin
              rep_n = rep_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          hold_n  = '0;
          rep_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wbc_btn_array.sv
// NKEY-channel button front end; one independent channel per key.
// The release pulse port is named rel.
module wbc_btn_array #(
  parameter int          NKEY        = 4,
  parameter int          DEBOUNCE    = 10,
  parameter int          LONGKEY     = 1000,
  parameter int          REPEAT      = 0,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter logic [31:0] TOGGLE_MASK = 32'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena_ms,
  input  logic [NKEY-1:0] but,
  output logic [NKEY-1:0] out,
  output logic [NKEY-1:0] press,
  output logic [NKEY-1:0] rel,
  output logic [NKEY-1:0] click,
  output logic [NKEY-1:0] long,
  output logic [NKEY-1:0] rpt
);

  for (genvar k = 0; k < NKEY; k++) begin : g_chan
    wbc_btn_chan #(
      .DEBOUNCE  (DEBOUNCE),
      .LONGKEY   (LONGKEY),
      .REPEAT    (REPEAT),
      .ACTIVE_LOW(ACTIVE_LOW),
      .TOGGLE    (TOGGLE_MASK[k])
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .ena_ms(ena_ms),
      .but   (but[k]),
      .out   (out[k]),
      .press (press[k]),
      .rel   (rel[k]),
      .click (click[k]),
      .long  (long[k]),
      .rpt   (rpt[k])
    );
  end

endmodule

// File: tb/tb_wbc_btn_array.sv
// Randomised bench for wbc_btn_array against a millisecond-level
// behavioural model of each button channel.
module tb_wbc_btn_array;

  localparam int NKEY = 2;
  localparam int DEB  = 3;
  localparam int LK   = 8;
  localparam int RP   = 4;
  localparam logic [NKEY-1:0] TM = 2'b10;

  logic clk = 1'b0;
  logic rst, ena_ms;
  logic [NKEY-1:0] but, out, press, rel, click, lng, rpt;

  always #5 clk = ~clk;

  wbc_btn_array #(
    .NKEY       (NKEY),
    .DEBOUNCE   (DEB),
    .LONGKEY    (LK),
    .REPEAT     (RP),
    .ACTIVE_LOW (1'b1),
    .TOGGLE_MASK(32'(TM))
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ena_ms(ena_ms),
    .but   (but),
    .out   (out),
    .press (press),
    .rel   (rel),
    .click (click),
    .long  (lng),
    .rpt   (rpt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: pressed-sample history, accepted level, strobes of stable
  // disagreement, ms held since press, long flag, toggle state.
  bit hist[NKEY][3];
  bit acc[NKEY];
  int nstab[NKEY];
  bit held[NKEY];
  int hms[NKEY];
  bit islong[NKEY];
  bit tog[NKEY];
  logic [NKEY-1:0] e_press, e_rel, e_click, e_long, e_rpt, e_out;

  task automatic model_step(input logic r, input logic e,
                            input logic [NKEY-1:0] b);
    bit p, s, prv, cm;
    for (int k = 0; k < NKEY; k++) begin
      p = ~b[k];
      e_press[k] = 1'b0;
      e_rel[k]   = 1'b0;
      e_click[k] = 1'b0;
      e_long[k]  = 1'b0;
      e_rpt[k]   = 1'b0;
      if (r) begin
        hist[k][0] = p;
        hist[k][1] = p;
        hist[k][2] = p;
        acc[k]     = p;
        nstab[k]   = 0;
        held[k]    = 1'b0;
        hms[k]     = 0;
        islong[k]  = 1'b0;
        tog[k]     = 1'b0;
      end else begin
        s   = hist[k][1];
        prv = hist[k][2];
        cm  = 1'b0;
        if (s != prv || s == acc[k]) nstab[k] = 0;
        else if (e) begin
          nstab[k]++;
          if (nstab[k] == DEB) begin
            cm = 1'b1;
            nstab[k] = 0;
          end
        end
        if (cm && s) begin
          e_press[k] = 1'b1;
          acc[k]     = 1'b1;
          held[k]    = 1'b1;
          hms[k]     = 0;
          islong[k]  = 1'b0;
          if (TM[k]) tog[k] = ~tog[k];
        end else if (cm) begin
          e_rel[k]   = 1'b1;
          e_click[k] = ~islong[k];
          acc[k]     = 1'b0;
          held[k]    = 1'b0;
          islong[k]  = 1'b0;
        end else if (held[k] && e) begin
          hms[k]++;
          if (hms[k] == LK) begin
            e_long[k] = 1'b1;
            islong[k] = 1'b1;
          end else if (hms[k] > LK && ((hms[k] - LK) % RP) == 0) begin
            e_rpt[k] = 1'b1;
          end
        end
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = p;
      end
      e_out[k] = TM[k] ? tog[k] : acc[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, ena_ms, but);
    #1;
    check("out",   32'(out),   32'(e_out));
    check("press", 32'(press), 32'(e_press));
    check("rel",   32'(rel),   32'(e_rel));
    check("click", 32'(click), 32'(e_click));
    check("long",  32'(lng),   32'(e_long));
    check("rpt",   32'(rpt),   32'(e_rpt));
    @(negedge clk);
  endtask

  int left[NKEY];
  bit lvl[NKEY];

  initial begin
    rst    = 1'b1;
    ena_ms = 1'b0;
    but    = 2'b10;
    tick();
    tick();
    check("rst_out", 32'(out), 32'h1);
    rst = 1'b0;
    for (int k = 0; k < NKEY; k++) begin
      lvl[k]  = (k == 0);
      left[k] = 0;
    end
    for (int cyc = 0; cyc < 9000; cyc++) begin
      ena_ms = (cyc < 8000) ? (cyc % 5 == 4) : 1'b1;
      for (int k = 0; k < NKEY; k++) begin
        if (left[k] == 0) begin
          lvl[k] = ~lvl[k];
          if ($urandom_range(0, 3) == 0) left[k] = $urandom_range(1, 12);
          else left[k] = $urandom_range(20, 200);
        end
        left[k]--;
        but[k] = ~lvl[k];
      end
      rst = (cyc > 100) && ($urandom_range(0, 799) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
